// File: rtl/uart_top.sv
// Full-duplex UART, 8N1 by default. Define UART_PARITY_EN to add an even-parity bit
// in both directions (11-bit frames).
module uart_top #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  input  logic       tx_enable,
  input  logic [7:0] tx_parallel,
  output logic [7:0] rx_parallel,
  output logic       rx_ready,
  output logic       tx_ready,
  output logic       tx_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
`ifdef UART_PARITY_EN
    , RX_PARITY
`endif
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
`ifdef UART_PARITY_EN
    , TX_PARITY
`endif
  } tx_state_t;

  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_meta, rx_sync, rx_sync_d;
  logic            rx_par_ok;

  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_byte;

`ifndef UART_PARITY_EN
  assign rx_par_ok = 1'b1;
`endif

  // rx_sync_d only exists to spot the synchronised 1->0 edge while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_sync_d   <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_parallel <= '0;
      rx_ready    <= 1'b1;
`ifdef UART_PARITY_EN
      rx_par_ok   <= 1'b1;
`endif
    end else begin
      rx_meta   <= rx_data;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_sync_d && !rx_sync) begin
            rx_state <= RX_START;
            rx_ready <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            if (rx_sync) begin
              rx_state <= RX_IDLE;
              rx_ready <= 1'b1;
            end else begin
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt           <= '0;
            rx_shift[rx_bit] <= rx_sync;
            rx_bit           <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == LAST) begin
            rx_cnt    <= '0;
            rx_par_ok <= (rx_sync == ^rx_shift);
            rx_state  <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              if (rx_par_ok) rx_parallel <= rx_shift;
              rx_ready <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) begin
            rx_ready <= 1'b1;
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_ready <= 1'b1;
      tx_data  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_enable) begin
            tx_byte  <= tx_parallel;
            tx_ready <= 1'b0;
            tx_data  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= tx_byte[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_data  <= ^tx_byte;
              tx_state <= TX_PARITY;
`else
              tx_data  <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_data <= tx_byte[tx_bit + 3'd1];
              tx_bit  <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_data  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top at 16 clk/bit: frames are built from the bit-level
// frame definition and compared cycle by cycle (TX) or against the last good byte (RX).
module tb_uart_top;

  localparam int C = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data;
  logic       tx_enable;
  logic [7:0] tx_parallel;
  logic [7:0] rx_parallel;
  logic       rx_ready;
  logic       tx_ready;
  logic       tx_data;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_rx = 8'h00;

  always #5 clk = ~clk;

  uart_top #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .tx_enable   (tx_enable),
    .tx_parallel (tx_parallel),
    .rx_parallel (rx_parallel),
    .rx_ready    (rx_ready),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level of bit slot i of a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Entered at the negedge right after the edge that started the frame
  task automatic tx_check_frame(input logic [7:0] b);
    for (int j = 0; j < NB*C; j++) begin
      check_eq("tx_bit", tx_data, frame_bit(b, j / C));
      if (j == 0 || j == NB*C-1) check_eq("tx_busy", tx_ready, 1'b0);
      if (j == 3*C) tx_parallel = 8'($urandom);
      @(negedge clk);
    end
    check_eq("tx_done_ready", tx_ready, 1'b1);
    check_eq("tx_done_line", tx_data, 1'b1);
  endtask

  task automatic tx_send(input logic [7:0] b);
    tx_enable   = 1'b1;
    tx_parallel = b;
    @(negedge clk);
    tx_enable = 1'b0;
    tx_check_frame(b);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int stop_cycles);
    int len;
    for (int i = 0; i < NB; i++) begin
      len = (i == NB-1) ? stop_cycles : C;
      for (int j = 0; j < len; j++) begin
        rx_data = (i == NB-1) ? stop_bit : frame_bit(b, i);
        if (i == 5 && j == 0) check_eq("rx_busy", rx_ready, 1'b0);
        if (i == NB-1 && j == 8) check_eq("rx_busy_stop", rx_ready, 1'b0);
        @(negedge clk);
      end
    end
    if (stop_bit) begin
      exp_rx = b;
      check_eq("rx_ready_done", rx_ready, 1'b1);
      check_eq("rx_byte", rx_parallel, exp_rx);
      rx_data = 1'b1;
    end else begin
      check_eq("rx_ferr_wait", rx_ready, 1'b0);
      check_eq("rx_ferr_hold", rx_parallel, exp_rx);
      rx_data = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("rx_ferr_ready", rx_ready, 1'b1);
      check_eq("rx_ferr_keep", rx_parallel, exp_rx);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    rst         = 1'b1;
    rx_data     = 1'b1;
    tx_enable   = 1'b0;
    tx_parallel = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_parallel", rx_parallel, 8'h00);
    check_eq("rst_rx_ready", rx_ready, 1'b1);
    check_eq("rst_tx_ready", tx_ready, 1'b1);
    check_eq("rst_tx_data", tx_data, 1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    tx_send(8'hA5);
    rx_send(8'h3C, 1'b1, C);

    // false start: 4-cycle glitch
    rx_data = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("glitch_dip", rx_ready, 1'b0);
    rx_data = 1'b1;
    repeat (16) @(negedge clk);
    check_eq("glitch_ready", rx_ready, 1'b1);
    check_eq("glitch_keep", rx_parallel, exp_rx);

    rx_send(8'h55, 1'b0, 2*C);

    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      if ($urandom_range(3) == 0) rx_send(b, 1'b0, 24 + int'($urandom_range(15)));
      else                        rx_send(b, 1'b1, C);
      tx_send(8'($urandom));
    end

    // full duplex: enable held through two TX frames while receiving 0xFF
    b = 8'($urandom);
    fork
      rx_send(8'hFF, 1'b1, C);
      begin
        tx_enable   = 1'b1;
        tx_parallel = b;
        @(negedge clk);
        tx_check_frame(b);
        tx_parallel = b;
        @(negedge clk);
        tx_enable = 1'b0;
        tx_check_frame(b);
      end
    join

    // reset in the middle of a TX frame and an RX frame
    tx_enable   = 1'b1;
    tx_parallel = 8'h00;
    rx_data     = 1'b0;
    @(negedge clk);
    tx_enable = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("pre_rst_tx_data", tx_data, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_rx = 8'h00;
    check_eq("mid_rst_tx_data", tx_data, 1'b1);
    check_eq("mid_rst_tx_ready", tx_ready, 1'b1);
    check_eq("mid_rst_rx_ready", rx_ready, 1'b1);
    check_eq("mid_rst_rx_parallel", rx_parallel, exp_rx);
    rx_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (10) @(negedge clk);
      check_eq("post_rst_tx_data", tx_data, 1'b1);
      check_eq("post_rst_tx_ready", tx_ready, 1'b1);
      check_eq("post_rst_rx_ready", rx_ready, 1'b1);
      check_eq("post_rst_rx_parallel", rx_parallel, exp_rx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
